// File: rtl/iw_writeback_unit.sv
// iw_writeback_unit
//   Writeback stage behind the IM/IW pipeline register. The IM/IW register
//   updates on the falling edge of clk, and this block samples it on the
//   rising edge. It then:
//     - resolves the destination register and the result value,
//     - drives the register-file write port with a valid/ready handshake,
//     - stalls upstream while a write is waiting on the port,
//     - issues one-cycle PC redirects,
//     - mirrors the in-flight write for the bypass network,
//     - counts retired instructions.
//
// Ports
//   clk, rst_n          pipeline clock, async active-low reset
//   valid_in            IM/IW holds a live instruction (0 = bubble)
//   pc_in, O_in, D_in   instruction PC, ALU result/branch target, load data
//   res_data_sel_in     1 = write D_in, 0 = write O_in
//   write_to_reg_in     instruction writes the register file
//   dest_reg_sel_in     1 = rd_in, 0 = rt_in
//   rt_in, rd_in        candidate destination indices
//   update_pc_in        instruction redirects the PC
//   is_jal_in           jump-and-link (writes pc+4 to $31)
//   rf_ready            write port accepts the write this cycle
//   rf_we/waddr/wdata   registered write request
//   stall_out           rf_we & ~rf_ready, upstream must hold IM/IW
//   fwd_valid/reg/data  copy of the write request for forwarding
//   pc_update_en/val    registered one-cycle redirect pulse and target
//   retired_count       retired-instruction counter (wraps)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no write outstanding, rf_we=0, every valid input is captured
// WRITE  | write presented on the port, waiting for rf_ready
module iw_writeback_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] O_in,
  input  logic [31:0] D_in,
  input  logic        res_data_sel_in,
  input  logic        write_to_reg_in,
  input  logic        dest_reg_sel_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  input  logic        update_pc_in,
  input  logic        is_jal_in,
  input  logic        rf_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_out,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data,
  output logic        pc_update_en,
  output logic [31:0] pc_update_val,
  output logic [31:0] retired_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  dest;
  logic [31:0] result;
  logic        wr_req;
  logic        capture;
  logic        retire_wr;
  logic        retire_nw;
  logic [1:0]  retire_sum;
  logic        owe_q;
  logic        owe_d;
  logic        count_en;

  assign rf_we     = (state_q == ST_WRITE);
  assign stall_out = rf_we & ~rf_ready;
  assign capture   = valid_in & ~stall_out;

  assign fwd_valid = rf_we;
  assign fwd_reg   = rf_waddr;
  assign fwd_data  = rf_wdata;

  always_comb begin
    dest   = dest_reg_sel_in ? rd_in : rt_in;
    result = res_data_sel_in ? D_in : O_in;
    if (is_jal_in) begin
      dest   = 5'd31;
      result = pc_in + 32'd4;
    end
  end

  // Writes to $0 never reach the port; such instructions retire on capture.
  assign wr_req = valid_in & (write_to_reg_in | is_jal_in) & (dest != 5'd0);

  // A completing write and a captured non-writing instruction can both
  // retire on the same edge. Only one count is taken per edge, so the
  // second is owed and paid on the next edge. The owed bit always drains
  // before the FSM can re-enter WRITE, because the IDLE->WRITE edge itself
  // retires nothing. That bounds the debt to a single instruction.
  assign retire_wr  = rf_we & rf_ready;
  assign retire_nw  = capture & ~wr_req;
  assign retire_sum = {1'b0, retire_wr} + {1'b0, retire_nw} + {1'b0, owe_q};
  assign count_en   = |retire_sum;
  assign owe_d      = retire_sum[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (capture && wr_req) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (rf_ready) state_d = (capture && wr_req) ? ST_WRITE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rf_waddr      <= 5'd0;
      rf_wdata      <= 32'd0;
      pc_update_en  <= 1'b0;
      pc_update_val <= 32'd0;
      retired_count <= 32'd0;
      owe_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture && wr_req) begin
        rf_waddr <= dest;
        rf_wdata <= result;
      end
      // The redirect fires on capture, independent of any pending write.
      pc_update_en <= capture & update_pc_in;
      if (capture && update_pc_in) pc_update_val <= O_in;
      if (count_en) retired_count <= retired_count + 32'd1;
      owe_q <= owe_d;
    end
  end

endmodule

// File: tb/tb_iw_writeback_unit.sv
module tb_iw_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] O_in = '0;
  logic [31:0] D_in = '0;
  logic        res_data_sel_in = 1'b0;
  logic        write_to_reg_in = 1'b0;
  logic        dest_reg_sel_in = 1'b0;
  logic [4:0]  rt_in = '0;
  logic [4:0]  rd_in = '0;
  logic        update_pc_in = 1'b0;
  logic        is_jal_in = 1'b0;
  logic        rf_ready = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_out;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        pc_update_en;
  logic [31:0] pc_update_val;
  logic [31:0] retired_count;

  int n_cmp = 0;
  int n_err = 0;

  iw_writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in),
    .O_in(O_in), .D_in(D_in), .res_data_sel_in(res_data_sel_in),
    .write_to_reg_in(write_to_reg_in), .dest_reg_sel_in(dest_reg_sel_in),
    .rt_in(rt_in), .rd_in(rd_in), .update_pc_in(update_pc_in),
    .is_jal_in(is_jal_in), .rf_ready(rf_ready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .stall_out(stall_out),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .pc_update_en(pc_update_en), .pc_update_val(pc_update_val),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Reference model: one pending write slot, a retirement debt counter.
  bit          m_busy;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_pcen;
  logic [31:0] m_pcval;
  logic [31:0] m_count;
  int          m_owed;

  task automatic model_reset();
    m_busy = 0; m_addr = '0; m_data = '0; m_pcen = 0; m_pcval = '0;
    m_count = '0; m_owed = 0;
  endtask

  task automatic model_edge();
    bit stall, cap, wants;
    logic [4:0] d;
    logic [31:0] v;
    int ev;
    stall = m_busy && !rf_ready;
    cap   = valid_in && !stall;
    d = is_jal_in ? 5'd31 : (dest_reg_sel_in ? rd_in : rt_in);
    v = is_jal_in ? pc_in + 32'd4 : (res_data_sel_in ? D_in : O_in);
    wants = cap && (write_to_reg_in || is_jal_in) && (d != 5'd0);
    ev = 0;
    if (m_busy && rf_ready) begin ev++; m_busy = 0; end
    if (cap) begin
      if (wants) begin m_busy = 1; m_addr = d; m_data = v; end
      else ev++;
    end
    m_pcen = cap && update_pc_in;
    if (m_pcen) m_pcval = O_in;
    m_owed += ev;
    if (m_owed > 0) begin m_count = m_count + 32'd1; m_owed--; end
  endtask

  task automatic clear_inputs();
    valid_in = 0; pc_in = '0; O_in = '0; D_in = '0; res_data_sel_in = 0;
    write_to_reg_in = 0; dest_reg_sel_in = 0; rt_in = '0; rd_in = '0;
    update_pc_in = 0; is_jal_in = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); rf_ready = 0; rst_n = 0;
    @(negedge clk); #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data, pc_update_en,
         pc_update_val, retired_count, stall_out} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got we=%0b addr=%0d data=%h pc_en=%0b count=%0d stall=%0b, want all 0",
               rf_we, rf_waddr, rf_wdata, pc_update_en, retired_count, stall_out);
    end
    @(negedge clk);
    rst_n = 1;
    valid_in = 1; write_to_reg_in = 1; dest_reg_sel_in = 1; rd_in = 5'd3; O_in = 32'hAB;
    @(posedge clk); #1;
    n_cmp++;
    if (rf_we !== 1'b1) begin
      n_err++; $display("FAIL reset_setup_write: rf_we=%0b want 1", rf_we);
    end
    @(negedge clk);
    rst_n = 0; #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data, pc_update_en,
         pc_update_val, retired_count, stall_out} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_write: got we=%0b addr=%0d data=%h count=%0d stall=%0b, want all 0",
               rf_we, rf_waddr, rf_wdata, retired_count, stall_out);
    end
    @(negedge clk);
    clear_inputs(); rf_ready = 1; rst_n = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (rf_we !== 1'b0 || retired_count !== 32'd0) begin
      n_err++; $display("FAIL reset_release: we=%0b count=%0d, want we=0 count=0", rf_we, retired_count);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_rd();
    valid_in = 1; write_to_reg_in = 1; dest_reg_sel_in = 1; rd_in = 5'd5; rt_in = 5'd12;
    res_data_sel_in = 0; O_in = 32'h1234; D_in = 32'h5555; rf_ready = 1;
    @(posedge clk); #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data, retired_count} !==
        {1'b1, 5'd5, 32'h1234, 1'b1, 5'd5, 32'h1234, 32'd0}) begin
      n_err++;
      $display("FAIL alu_write: we=%0b addr=%0d data=%h fwd=%0b/%0d/%h count=%0d, want 1/5/00001234 fwd same count=0",
               rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_reg, fwd_data, retired_count);
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if (rf_we !== 1'b0 || retired_count !== 32'd1) begin
      n_err++; $display("FAIL alu_retire: we=%0b count=%0d, want we=0 count=1", rf_we, retired_count);
    end
    @(negedge clk);
  endtask

  task automatic test_load_stall();
    valid_in = 1; write_to_reg_in = 1; dest_reg_sel_in = 0; rt_in = 5'd9; rd_in = 5'd20;
    res_data_sel_in = 1; D_in = 32'hCAFEBABE; O_in = 32'h1111; rf_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    clear_inputs();
    valid_in = 1; write_to_reg_in = 1; dest_reg_sel_in = 1; rd_in = 5'd7; O_in = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (stall_out !== 1'b1) begin
        n_err++; $display("FAIL load_stall_%0d: stall_out=%0b want 1", i, stall_out);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({rf_we, rf_waddr, rf_wdata, retired_count} !== {1'b1, 5'd9, 32'hCAFEBABE, 32'd1}) begin
        n_err++;
        $display("FAIL load_hold_%0d: we=%0b addr=%0d data=%h count=%0d, want 1/9/cafebabe/1",
                 i, rf_we, rf_waddr, rf_wdata, retired_count);
      end
      @(negedge clk);
    end
    rf_ready = 1; #1;
    n_cmp++;
    if (stall_out !== 1'b0) begin
      n_err++; $display("FAIL load_unstall: stall_out=%0b want 0", stall_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, retired_count} !== {1'b1, 5'd7, 32'h77, 32'd2}) begin
      n_err++;
      $display("FAIL load_retire_next: we=%0b addr=%0d data=%h count=%0d, want 1/7/00000077/2",
               rf_we, rf_waddr, rf_wdata, retired_count);
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if (rf_we !== 1'b0 || retired_count !== 32'd3) begin
      n_err++; $display("FAIL load_drain: we=%0b count=%0d, want 0/3", rf_we, retired_count);
    end
    @(negedge clk);
  endtask

  task automatic test_jal();
    valid_in = 1; is_jal_in = 1; update_pc_in = 1; pc_in = 32'h00400010;
    O_in = 32'h00400100; rd_in = 5'd4; rt_in = 5'd6; rf_ready = 1;
    @(posedge clk); #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, pc_update_en, pc_update_val} !==
        {1'b1, 5'd31, 32'h00400014, 1'b1, 32'h00400100}) begin
      n_err++;
      $display("FAIL jal_issue: we=%0b addr=%0d data=%h pc_en=%0b pc_val=%h, want 1/31/00400014/1/00400100",
               rf_we, rf_waddr, rf_wdata, pc_update_en, pc_update_val);
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if ({rf_we, pc_update_en, pc_update_val, retired_count} !== {1'b0, 1'b0, 32'h00400100, 32'd4}) begin
      n_err++;
      $display("FAIL jal_after: we=%0b pc_en=%0b pc_val=%h count=%0d, want 0/0/00400100/4",
               rf_we, pc_update_en, pc_update_val, retired_count);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_bubble();
    valid_in = 1; write_to_reg_in = 1; dest_reg_sel_in = 1; rd_in = 5'd0; O_in = 32'hDEAD; rf_ready = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (rf_we !== 1'b0 || retired_count !== 32'd5) begin
      n_err++; $display("FAIL zero_reg: we=%0b count=%0d, want 0/5", rf_we, retired_count);
    end
    @(negedge clk); clear_inputs(); O_in = 32'hFFFF; write_to_reg_in = 1; rd_in = 5'd3; dest_reg_sel_in = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (rf_we !== 1'b0 || retired_count !== 32'd5) begin
      n_err++; $display("FAIL bubble: we=%0b count=%0d, want 0/5", rf_we, retired_count);
    end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_back_to_back();
    valid_in = 1; write_to_reg_in = 1; dest_reg_sel_in = 1; rd_in = 5'd10; O_in = 32'hA0; rf_ready = 1;
    @(posedge clk); #1;
    @(negedge clk); rd_in = 5'd11; O_in = 32'hB0;
    @(posedge clk); #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, retired_count} !== {1'b1, 5'd11, 32'hB0, 32'd6}) begin
      n_err++;
      $display("FAIL b2b_second: we=%0b addr=%0d data=%h count=%0d, want 1/11/000000b0/6",
               rf_we, rf_waddr, rf_wdata, retired_count);
    end
    @(negedge clk); write_to_reg_in = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (rf_we !== 1'b0 || retired_count !== 32'd7) begin
      n_err++; $display("FAIL b2b_nonwrite: we=%0b count=%0d, want 0/7", rf_we, retired_count);
    end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if (retired_count !== 32'd8) begin
      n_err++; $display("FAIL b2b_owed: count=%0d want 8", retired_count);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    rst_n = 0; clear_inputs(); #1;
    model_reset();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 600; i++) begin
      valid_in        = ($urandom_range(0, 9) < 8);
      pc_in           = $urandom() & 32'hFFFF_FFFC;
      O_in            = $urandom();
      D_in            = $urandom();
      res_data_sel_in = ($urandom_range(0, 1) == 1);
      write_to_reg_in = ($urandom_range(0, 2) != 0);
      dest_reg_sel_in = ($urandom_range(0, 1) == 1);
      rt_in           = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd_in           = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      is_jal_in       = ($urandom_range(0, 7) == 0);
      update_pc_in    = is_jal_in || ($urandom_range(0, 7) == 0);
      rf_ready        = ($urandom_range(0, 9) < 7);
      #1;
      n_cmp++;
      if (stall_out !== (m_busy && !rf_ready)) begin
        n_err++; $display("FAIL rand_stall[%0d]: stall_out=%0b want %0b", i, stall_out, m_busy && !rf_ready);
      end
      @(posedge clk); #1;
      model_edge();
      n_cmp++;
      if (rf_we !== m_busy || fwd_valid !== m_busy ||
          (m_busy && (rf_waddr !== m_addr || rf_wdata !== m_data ||
                      fwd_reg !== m_addr || fwd_data !== m_data)) ||
          pc_update_en !== m_pcen || pc_update_val !== m_pcval ||
          retired_count !== m_count) begin
        n_err++;
        $display("FAIL rand_state[%0d]: got we=%0b addr=%0d data=%h pc=%0b/%h cnt=%0d want we=%0b addr=%0d data=%h pc=%0b/%h cnt=%0d",
                 i, rf_we, rf_waddr, rf_wdata, pc_update_en, pc_update_val, retired_count,
                 m_busy, m_addr, m_data, m_pcen, m_pcval, m_count);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_rd();
    test_load_stall();
    test_jal();
    test_zero_bubble();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
